// File: rtl/can_tx_scheduler.sv
// Lowest-ID transmit scheduler that shares one CAN node between NUM_REQ mailboxes, with error retry.
// Optional WAIT watchdog enabled by defining CAN_TX_TIMEOUT_EN.
module can_tx_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned ID_W        = 11,
    parameter int unsigned RETRY_MAX   = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    input  logic                    bus_idle,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    input  logic                    tx_arb_lost,
    input  logic                    tx_error,
    output logic                    tx_start,
    output logic [SEL_W-1:0]        tx_sel,
    output logic [ID_W-1:0]         tx_id,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      req_fail,
    output logic                    busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_WAIT} state_t;

    state_t               state, state_next;
    logic [SEL_W-1:0]     tx_sel_next;
    logic [ID_W-1:0]      tx_id_next;
    logic                 tx_start_next;
    logic                 busy_next;
    logic [NUM_REQ-1:0]   ack_next, fail_next;
    logic [CNT_W-1:0]     cnt      [NUM_REQ];
    logic [CNT_W-1:0]     cnt_next [NUM_REQ];

    logic                 win_found;
    logic [SEL_W-1:0]     win_sel;
    logic [ID_W-1:0]      win_id;
    logic                 still_valid;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout;
    logic                 unused_ok;

    // Node busy is implied by our own WAIT state; kept only for interface completeness.
    assign unused_ok = tx_busy;

`ifdef CAN_TX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] wait_cnt;

    // Counts WAIT cycles; zero on the first WAIT cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                 wait_cnt <= '0;
        else if (state != S_WAIT) wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + TMO_W'(1);
    end

    assign timeout = (state == S_WAIT) && (wait_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYC);
    assign timeout    = 1'b0;
`endif

    // Lowest identifier among valid slots; strict compare keeps the lower index on ties.
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        win_id    = '1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_valid[i] && (!win_found || (req_id[i*ID_W +: ID_W] < win_id))) begin
                win_found = 1'b1;
                win_sel   = SEL_W'(i);
                win_id    = req_id[i*ID_W +: ID_W];
            end
        end
    end

    assign still_valid = req_valid[tx_sel];
    assign cnt_inc     = cnt[tx_sel] + CNT_W'(1);

    always_comb begin
        state_next    = state;
        tx_sel_next   = tx_sel;
        tx_id_next    = tx_id;
        tx_start_next = 1'b0;
        ack_next      = '0;
        fail_next     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) cnt_next[i] = cnt[i];

        case (state)
            S_IDLE: begin
                if ((|req_valid) && bus_idle) state_next = S_SELECT;
            end
            S_SELECT: begin
                if (win_found) begin
                    tx_sel_next   = win_sel;
                    tx_id_next    = win_id;
                    tx_start_next = 1'b1;
                    state_next    = S_START;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Error (or watchdog) outranks arbitration loss, which outranks done.
                if (tx_error || timeout) begin
                    state_next = S_IDLE;
                    if (!still_valid) begin
                        cnt_next[tx_sel] = '0;
                    end else if (cnt_inc == CNT_W'(RETRY_MAX)) begin
                        cnt_next[tx_sel]  = '0;
                        fail_next[tx_sel] = 1'b1;
                    end else begin
                        cnt_next[tx_sel] = cnt_inc;
                    end
                end else if (tx_arb_lost) begin
                    state_next = S_IDLE;
                    if (!still_valid) cnt_next[tx_sel] = '0;
                end else if (tx_done) begin
                    state_next       = S_IDLE;
                    cnt_next[tx_sel] = '0;
                    if (still_valid) ack_next[tx_sel] = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_sel   <= '0;
            tx_id    <= '0;
            req_ack  <= '0;
            req_fail <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] <= '0;
        end else begin
            state    <= state_next;
            tx_start <= tx_start_next;
            tx_sel   <= tx_sel_next;
            tx_id    <= tx_id_next;
            req_ack  <= ack_next;
            req_fail <= fail_next;
            busy     <= busy_next;
            for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] <= cnt_next[i];
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scoreboard bench for can_tx_scheduler: expected starts/acks/fails are queued as stimulus is driven.
module tb_can_tx_scheduler;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned ID_W        = 11;
    localparam int unsigned RETRY_MAX   = 3;
    localparam int unsigned TIMEOUT_CYC = 16;

    localparam int K_START = 0;
    localparam int K_ACK   = 1;
    localparam int K_FAIL  = 2;

    localparam int P_DONE = 0;
    localparam int P_ARB  = 1;
    localparam int P_ERR  = 2;
    localparam int P_BOTH = 3;

    logic                    CLK;
    logic                    RST;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*ID_W-1:0] req_id;
    logic                    bus_idle;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    tx_arb_lost;
    logic                    tx_error;
    logic                    tx_start;
    logic [SEL_W-1:0]        tx_sel;
    logic [ID_W-1:0]         tx_id;
    logic [NUM_REQ-1:0]      req_ack;
    logic [NUM_REQ-1:0]      req_fail;
    logic                    busy;

    can_tx_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .SEL_W      (SEL_W),
        .ID_W       (ID_W),
        .RETRY_MAX  (RETRY_MAX),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .bus_idle   (bus_idle),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_arb_lost(tx_arb_lost),
        .tx_error   (tx_error),
        .tx_start   (tx_start),
        .tx_sel     (tx_sel),
        .tx_id      (tx_id),
        .req_ack    (req_ack),
        .req_fail   (req_fail),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        int          sel;
        int          id;
        logic [31:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_start(input int sel, input int id);
        ev_t e;
        e.kind = K_START; e.sel = sel; e.id = id; e.vec = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_result(input int kind, input logic [31:0] vec);
        ev_t e;
        e.kind = kind; e.sel = 0; e.id = 0; e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic compare_ev(input int kind, input logic [31:0] sel, input logic [31:0] id,
                              input logic [31:0] vec);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            if (kind == K_START) begin
                check("sb_tx_sel", sel, 32'(e.sel));
                check("sb_tx_id", id, 32'(e.id));
            end else begin
                check("sb_result_vec", vec, e.vec);
            end
        end
    endtask

    // Output monitor: every start/ack/fail must match the head of the expectation queue.
    always @(negedge CLK) begin
        if (!RST) begin
            if (tx_start)        compare_ev(K_START, 32'(tx_sel), 32'(tx_id), 0);
            if (req_ack != '0)   compare_ev(K_ACK, 0, 0, 32'(req_ack));
            if (req_fail != '0)  compare_ev(K_FAIL, 0, 0, 32'(req_fail));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input int slot, input int id);
        req_id[slot*ID_W +: ID_W] = ID_W'(id);
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!tx_start && cyc < 40);
        if (!tx_start) check("start_timeout", 32'(tx_start), 1);
    endtask

    task automatic pulse(input int kind);
        tick();
        case (kind)
            P_DONE:  tx_done = 1'b1;
            P_ARB:   tx_arb_lost = 1'b1;
            P_ERR:   tx_error = 1'b1;
            default: begin tx_done = 1'b1; tx_error = 1'b1; end
        endcase
        tick();
        tx_done     = 1'b0;
        tx_arb_lost = 1'b0;
        tx_error    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int order [4];
        int ids   [4];

        RST = 1'b1; req_valid = '0; req_id = '0; bus_idle = 1'b1; tx_busy = 1'b0;
        tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
        repeat (3) tick();
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_sel", 32'(tx_sel), 0);
        check("rst_tx_id", 32'(tx_id), 0);
        check("rst_ack_fail", 32'({req_ack, req_fail}), 0);
        RST = 1'b0;
        tick();

        // Single request, latency and ack.
        set_id(2, 'h123);
        push_start(2, 'h123);
        req_valid = 4'b0100;
        wait_start(cyc);
        check("start_latency", 32'(cyc), 2);
        check("single_busy", 32'(busy), 1);
        push_result(K_ACK, 32'b0100);
        pulse(P_DONE);
        check("single_ack", 32'(req_ack), 32'b0100);
        check("single_busy_low", 32'(busy), 0);
        req_valid = '0;
        tick();
        check("ack_one_cycle", 32'(req_ack), 0);

        // Priority order with an ID tie.
        ids   = '{'h300, 'h050, 'h050, 'h7FF};
        order = '{1, 2, 0, 3};
        for (int i = 0; i < 4; i++) set_id(i, ids[i]);
        for (int k = 0; k < 4; k++) begin
            push_start(order[k], ids[order[k]]);
            if (k == 0) req_valid = 4'b1111;
            wait_start(cyc);
            push_result(K_ACK, 32'(1) << order[k]);
            pulse(P_DONE);
            req_valid[order[k]] = 1'b0;
        end
        tick();

        // Arbitration loss does not touch the retry count.
        set_id(0, 'h100);
        push_start(0, 'h100);
        req_valid = 4'b0001;
        wait_start(cyc);
        pulse(P_ERR);
        push_start(0, 'h100);
        wait_start(cyc);
        pulse(P_ARB);
        check("arb_no_result", 32'({req_ack, req_fail}), 0);
        push_start(0, 'h100);
        wait_start(cyc);
        pulse(P_ERR);
        push_start(0, 'h100);
        wait_start(cyc);
        push_result(K_FAIL, 32'b0001);
        pulse(P_ERR);
        check("arb_then_fail", 32'(req_fail), 32'b0001);
        req_valid = '0;
        tick();

        // Retry exhaustion then fresh counter on re-grant.
        set_id(3, 'h7FF);
        push_start(3, 'h7FF);
        req_valid = 4'b1000;
        for (int n = 1; n <= 3; n++) begin
            wait_start(cyc);
            if (n == 3) push_result(K_FAIL, 32'b1000);
            push_start(3, 'h7FF);
            pulse(P_ERR);
        end
        check("exhaust_fail", 32'(req_fail), 32'b1000);
        for (int n = 1; n <= 2; n++) begin
            wait_start(cyc);
            push_start(3, 'h7FF);
            pulse(P_ERR);
        end
        wait_start(cyc);
        push_result(K_ACK, 32'b1000);
        pulse(P_DONE);
        check("regrant_ack", 32'(req_ack), 32'b1000);
        req_valid = '0;
        tick();

        // Coincident done+error counts as error.
        set_id(1, 'h010);
        push_start(1, 'h010);
        req_valid = 4'b0010;
        wait_start(cyc);
        push_start(1, 'h010);
        pulse(P_BOTH);
        check("both_no_ack", 32'(req_ack), 0);
        wait_start(cyc);
        push_result(K_ACK, 32'b0010);
        pulse(P_DONE);
        req_valid = '0;
        tick();

        // Withdrawal before completion suppresses the ack.
        set_id(2, 'h222);
        push_start(2, 'h222);
        req_valid = 4'b0100;
        wait_start(cyc);
        req_valid = '0;
        pulse(P_DONE);
        check("withdraw_no_ack", 32'(req_ack), 0);
        check("withdraw_busy", 32'(busy), 0);
        tick();

        // Asynchronous reset in WAIT.
        set_id(0, 'h055);
        push_start(0, 'h055);
        req_valid = 4'b0001;
        wait_start(cyc);
        tick();
        check("wait_busy", 32'(busy), 1);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sel_id", 32'({tx_sel, tx_id}), 0);
        check("mid_rst_start", 32'(tx_start), 0);
        tick();
        push_start(0, 'h055);
        RST = 1'b0;
        wait_start(cyc);
        push_result(K_ACK, 32'b0001);
        pulse(P_DONE);
        req_valid = '0;
        tick();

`ifdef CAN_TX_TIMEOUT_EN
        // Watchdog acts as an error after TIMEOUT_CYC WAIT cycles.
        set_id(1, 'h0AA);
        push_start(1, 'h0AA);
        req_valid = 4'b0010;
        wait_start(cyc);
        push_start(1, 'h0AA);
        wait_start(cyc);
        check("timeout_restart", 32'(cyc), 32'(TIMEOUT_CYC + 3));
        push_result(K_ACK, 32'b0010);
        pulse(P_DONE);
        req_valid = '0;
        tick();
`endif

        repeat (4) tick();
        check("sb_empty", 32'(exp_q.size()), 0);
        check("final_busy", 32'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares the transmit path of one custom_can_node between NUM_REQ local requesters (mailboxes).
- Selects the pending frame with the lowest CAN identifier, which mirrors bus arbitration, and starts it in the node.
- Tracks the outcome of each attempt (success, arbitration loss, error), retries errored frames, and returns a per-requester ack or fail pulse.
- Sits between the mailbox registers and the node's TX interface; frame data is muxed outside the block using tx_sel.

Parameters:
- NUM_REQ, 4, number of requesters.
- SEL_W, 2, width of tx_sel; must satisfy 2**SEL_W >= NUM_REQ.
- ID_W, 11, identifier width (standard frame).
- RETRY_MAX, 8, number of errored attempts before a frame is dropped; legal range 1..15.
- TIMEOUT_CYC, 4096, WAIT watchdog limit in clock cycles (used only with the optional feature).

Ports:
- CLK  in  1  system/CAN clock.
- RST  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  level; frame pending in slot i, held until ack/fail.
- req_id  in  NUM_REQ*ID_W  slot i identifier at bits [i*ID_W +: ID_W].
- bus_idle  in  1  node reports bus idle (intermission complete).
- tx_busy  in  1  node is transmitting.
- tx_done  in  1  pulse; frame sent and ACKed.
- tx_arb_lost  in  1  pulse; node lost arbitration.
- tx_error  in  1  pulse; bit, ACK or form error on own frame.
- tx_start  out  1  one-cycle pulse that launches the frame.
- tx_sel  out  SEL_W  index of the granted slot; stable from SELECT until return to IDLE.
- tx_id  out  ID_W  identifier of the granted slot, latched.
- req_ack  out  NUM_REQ  one-cycle pulse per slot on success.
- req_fail  out  NUM_REQ  one-cycle pulse per slot when dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE; tx_start, req_ack, req_fail, busy all 0; tx_sel=0; tx_id=0; all retry counters 0. Reset mid-WAIT abandons the attempt with no ack or fail.
- Clock and reset: single clock CLK; RST asynchronous, active-high.
- IDLE: if any req_valid=1 and bus_idle=1, go to SELECT next cycle.
- SELECT, 1 cycle:
  - winner = valid slot with minimum req_id; on equal IDs, the lower index wins.
  - Latch tx_sel and tx_id.
  - If no slot is still valid (withdrawn this cycle), return to IDLE.
- START, 1 cycle: tx_start=1, then go to WAIT. Latency from valid+bus_idle at IDLE to tx_start high is 2 cycles.
- WAIT: hold until a completion pulse arrives. Precedence when pulses coincide: tx_error > tx_arb_lost > tx_done.
  - tx_done: req_ack[tx_sel] pulses for 1 cycle (only if req_valid[tx_sel] is still 1); retry counter cleared; go to IDLE.
  - tx_arb_lost: no counter change; go to IDLE; the next cycle re-arbitrates from the current req_valid.
  - tx_error: counter[tx_sel]++.
    - If the new value equals RETRY_MAX: req_fail[tx_sel] pulses, counter cleared.
    - Then go to IDLE; an unfailed frame is retried via normal selection.
- Withdrawal in WAIT: if req_valid[tx_sel] drops, the attempt completes normally, req_ack is suppressed, and the counter is cleared on any outcome.
- Counters: width 4; saturating is not needed because the drop at RETRY_MAX resets the counter.
- Output timing: req_ack and req_fail are registered and assert the cycle after the completion pulse; at most one bit is high per cycle.
- Between attempts: busy falls in IDLE; at least one IDLE cycle separates consecutive tx_start pulses.

Optional Feature:
- Macro: CAN_TX_TIMEOUT_EN.
- Defined: a WAIT cycle counter runs.
  - When it reaches TIMEOUT_CYC with no completion pulse, the event is treated exactly as tx_error (retry count, possible fail).
  - The counter clears on WAIT entry.
- Undefined: no watchdog; WAIT waits indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- Single request: slot2 valid, id 0x123, bus_idle=1 -> tx_start 2 cycles later, tx_sel=2, tx_id=0x123; tx_done -> req_ack=0b0100 for 1 cycle, busy=0.
- Priority: slots 0..3 with ids 0x300, 0x050, 0x050, 0x7FF -> slot1 granted first; then slot2, slot0, slot3 in order after each done.
- Arbitration loss: slot0 granted, tx_arb_lost -> no ack/fail, counter unchanged, slot0 re-granted with a second tx_start.
- Retry exhaustion: RETRY_MAX=3, slot3 receives 3 tx_error pulses -> req_fail=0b1000 once after the third; slot3 is re-eligible only if still valid with counter 0.
- Coincident pulses and reset: tx_done and tx_error in the same cycle -> treated as error (no ack). RST asserted mid-WAIT -> outputs 0 immediately, state IDLE.
- With CAN_TX_TIMEOUT_EN, TIMEOUT_CYC=16, no completion -> counter increments at WAIT cycle 16, re-selection, tx_start again.
